simple_adapter_arb: RTL and testbench
=====================================

Name: simple_adapter_arb

Overview:
- Shares one 2:1 width packer (two WIDTH_DIN beats into one 2*WIDTH_DIN word) between NCH byte-stream requesters.
- A round-robin arbiter grants one channel per pair and locks it until that pair's second beat arrives, so pairs never interleave across channels.
- Sits between multiple byte producers and a single packed-word consumer. The output has no backpressure; each packed word is tagged with its source channel.

Parameters:
- NCH, 4, number of requesting channels (2..16; need not be a power of two)
- WIDTH_DIN, 8, input beat width
- HOLD_MAX, 64, max cycles to wait for a locked channel's second beat; 0 disables the timeout
- CHW (localparam), $clog2(NCH), channel index width

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- din_vld  in  NCH  per-channel beat valid
- din  in  NCH*WIDTH_DIN  per-channel beat; channel k at [k*WIDTH_DIN +: WIDTH_DIN]
- din_rdy  out  NCH  per-channel ready (combinational from state, pointer and din_vld)
- dout_vld  out  1  one-cycle pulse, packed word valid
- dout  out  2*WIDTH_DIN  packed word {first_beat, second_beat}
- dout_ch  out  CHW  source channel of dout
- err_drop  out  1  one-cycle pulse, half pair discarded on timeout

Behaviour:
- Reset (async assert, sync release):
  - dout_vld=0, dout=0, dout_ch=0, err_drop=0.
  - state=IDLE, rr_ptr=0, lock_ch=0, hold_cnt=0.
  - din_rdy=0 while rstn low.
- A beat transfers on channel k when din_vld[k] & din_rdy[k]. At most one din_rdy bit is high in any cycle.
- IDLE:
  - Winner g is the first k with din_vld[k]=1, searching rr_ptr, rr_ptr+1, ... and wrapping modulo NCH.
  - din_rdy = onehot(g) if any valid, else 0.
  - On transfer: hi_reg <= din[g], lock_ch <= g, hold_cnt <= 0, state <= HALF.
- HALF:
  - din_rdy = onehot(lock_ch). All other channels stall regardless of din_vld.
  - On transfer, the next cycle shows dout = {hi_reg, din[lock_ch]}, dout_ch = lock_ch and dout_vld = 1 for exactly one cycle.
  - Also on transfer: rr_ptr <= (lock_ch+1) mod NCH, state <= IDLE.
  - No transfer: hold_cnt <= hold_cnt+1.
  - If HOLD_MAX!=0 and hold_cnt==HOLD_MAX-1 with no transfer this cycle:
    - The half pair is dropped; err_drop pulses next cycle and dout_vld stays 0.
    - rr_ptr <= (lock_ch+1) mod NCH, state <= IDLE.
  - A transfer in the timeout cycle wins: no drop, normal output.
- Latency and throughput:
  - Second-beat acceptance to dout_vld is 1 cycle.
  - Max throughput is one packed word per 2 cycles: the IDLE cycle of the next pair may directly follow the completing HALF cycle.
- dout and dout_ch hold their last value when dout_vld=0. dout_vld and err_drop are never both 1.
- Fairness: a channel that just completed a pair has lowest priority next arbitration. Every continuously requesting channel is served within NCH pairs.
- The lock holds even if din_vld[lock_ch] deasserts; only the second beat or the timeout releases it.
- Reset mid-HALF discards hi_reg. After release the first beat from any channel is treated as the high half.
- rr_ptr wrap for non-power-of-two NCH: NCH-1 -> 0 explicitly, never via bit truncation.
- hold_cnt width is $clog2(HOLD_MAX+1) and it saturates; it is unused when HOLD_MAX=0.

Decomposition:
- No shared package is needed; CHW and the state encoding (IDLE=0, HALF=1) are localparams.
- One sub-module, simple_rr_arb, is natural. Parameter NCH; inputs req[NCH] and ptr[CHW]; outputs gnt onehot[NCH], gnt_idx[CHW], any. It is purely combinational priority rotation.
- The lock/packing FSM, hold counter and output registers live in simple_adapter_arb.

Test Plan:
- Single channel: NCH=4, only ch2 sends 0xA5 then 0x3C, back-to-back → one dout_vld with dout=0xA53C, dout_ch=2, one cycle after the 0x3C transfer.
- All four channels valid continuously after reset, 2 beats each → dout_ch sequence 0,1,2,3,0; din_rdy onehot every cycle; no pair mixing.
- Lock: ch1 sends 0x11 and then drops din_vld for 5 cycles while ch0/ch3 are valid → din_rdy stays 4'b0010; then ch1 sends 0x22 → dout=0x1122, dout_ch=1, next grant goes to ch3.
- Timeout: HOLD_MAX=4, ch0 sends one beat then idles → err_drop pulses once, 4 cycles after the first-beat transfer, with no dout_vld. Repeat with the second beat arriving on hold cycle 4 (cnt=3) → normal dout, no err_drop.
- Reset mid-HALF: ch2 first beat 0xFF, assert rstn low for 2 cycles → all outputs 0; after release ch2 sends 0x01,0x02 → dout=0x0102.
- Random soak: NCH=3, four runs of 1024 random bytes per channel, din_vld gated 20% random → per-channel golden {b[2i], b[2i+1]} order matches exactly; no err_drop with HOLD_MAX=0.

Source files
------------

// File: rtl/simple_adapter_arb_rr.sv
// simple_rr_arb
//   Purely combinational rotating-priority arbiter. It searches the
//   requests starting at ptr and wraps modulo NCH, so NCH does not have
//   to be a power of two.
//
// Ports
//   req     in   NCH   request vector
//   ptr     in   CHW   highest-priority index for this search (0..NCH-1)
//   gnt     out  NCH   one-hot grant, all zero when nothing requests
//   gnt_idx out  CHW   binary index of the granted request
//   any     out  1     at least one request present
module simple_rr_arb #(
  parameter  int NCH = 4,
  localparam int CHW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] ptr,
  output logic [NCH-1:0] gnt,
  output logic [CHW-1:0] gnt_idx,
  output logic           any
);

  // Walk NCH candidates starting at ptr and keep the first requester.
  // The wrap is done by subtracting NCH, not by truncating bits, so a
  // non-power-of-two channel count never visits a nonexistent channel.
  always_comb begin
    int k;
    k       = 0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      k = int'(ptr) + i;
      if (k >= NCH) begin
        k = k - NCH;
      end
      if (!any && req[k]) begin
        gnt[k]  = 1'b1;
        gnt_idx = CHW'(k);
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/simple_adapter_arb.sv
// simple_adapter_arb
//   Shares one 2:1 packer between NCH beat producers. A round-robin
//   arbiter picks a channel for the first beat of a pair and the channel
//   stays locked until its second beat arrives (or the hold timer
//   expires), so pairs from different channels never interleave.
//
// Ports
//   clk       in   1              clock
//   rstn      in   1              asynchronous active-low reset
//   din_vld   in   NCH            per-channel beat valid
//   din       in   NCH*WIDTH_DIN  per-channel beat, channel k at [k*WIDTH_DIN +: WIDTH_DIN]
//   din_rdy   out  NCH            per-channel ready, at most one bit high
//   dout_vld  out  1              one-cycle pulse, packed word valid
//   dout      out  2*WIDTH_DIN    {first_beat, second_beat}
//   dout_ch   out  CHW            source channel of dout
//   err_drop  out  1              one-cycle pulse, half pair discarded on timeout
module simple_adapter_arb #(
  parameter  int NCH       = 4,
  parameter  int WIDTH_DIN = 8,
  parameter  int HOLD_MAX  = 64,
  localparam int CHW       = $clog2(NCH)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NCH-1:0]           din_vld,
  input  logic [NCH*WIDTH_DIN-1:0] din,
  output logic [NCH-1:0]           din_rdy,
  output logic                     dout_vld,
  output logic [2*WIDTH_DIN-1:0]   dout,
  output logic [CHW-1:0]           dout_ch,
  output logic                     err_drop
);

  localparam int HCW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = (HOLD_MAX > 0) ? HCW'(HOLD_MAX - 1) : '0;
  localparam logic [CHW-1:0] LAST_CH   = CHW'(NCH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HALF = 1'b1
  } state_e;

  state_e                 state_q,    state_d;
  logic [CHW-1:0]         rr_ptr_q,   rr_ptr_d;
  logic [CHW-1:0]         lock_ch_q,  lock_ch_d;
  logic [HCW-1:0]         hold_cnt_q, hold_cnt_d;
  logic [WIDTH_DIN-1:0]   hi_q,       hi_d;
  logic                   dout_vld_q, dout_vld_d;
  logic [2*WIDTH_DIN-1:0] dout_q,     dout_d;
  logic [CHW-1:0]         dout_ch_q,  dout_ch_d;
  logic                   err_q,      err_d;

  logic [WIDTH_DIN-1:0] din_arr [NCH];
  logic [NCH-1:0]       gnt;
  logic [CHW-1:0]       gnt_idx;
  logic                 any_req;
  logic                 xfer;
  logic                 timeout;
  logic [CHW-1:0]       next_ptr;

  for (genvar g = 0; g < NCH; g++) begin : g_unpack
    assign din_arr[g] = din[g*WIDTH_DIN +: WIDTH_DIN];
  end

  simple_rr_arb #(
    .NCH (NCH)
  ) u_arb (
    .req     (din_vld),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any_req)
  );

  // Only one ready bit can be high, so any overlap means a beat moved.
  assign xfer = |(din_vld & din_rdy);

  // The channel that just finished (or timed out) gets lowest priority.
  assign next_ptr = (lock_ch_q == LAST_CH) ? '0 : lock_ch_q + 1'b1;

  // A second beat arriving in the last hold cycle beats the timeout.
  assign timeout = (HOLD_MAX != 0) && (state_q == HALF) && !xfer &&
                   (hold_cnt_q == HOLD_LAST);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_ch_q  <= '0;
      hold_cnt_q <= '0;
      hi_q       <= '0;
      dout_vld_q <= 1'b0;
      dout_q     <= '0;
      dout_ch_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_ch_q  <= lock_ch_d;
      hold_cnt_q <= hold_cnt_d;
      hi_q       <= hi_d;
      dout_vld_q <= dout_vld_d;
      dout_q     <= dout_d;
      dout_ch_q  <= dout_ch_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: capture the high half in IDLE, then wait in HALF
  // for the locked channel's second beat or for the hold timer to expire.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_ch_d  = lock_ch_q;
    hold_cnt_d = hold_cnt_q;
    hi_d       = hi_q;
    dout_vld_d = 1'b0;
    dout_d     = dout_q;
    dout_ch_d  = dout_ch_q;
    err_d      = timeout;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          hi_d       = din_arr[gnt_idx];
          lock_ch_d  = gnt_idx;
          hold_cnt_d = '0;
          state_d    = HALF;
        end
      end
      HALF: begin
        if (xfer) begin
          dout_vld_d = 1'b1;
          dout_d     = {hi_q, din_arr[lock_ch_q]};
          dout_ch_d  = lock_ch_q;
          rr_ptr_d   = next_ptr;
          state_d    = IDLE;
        end else begin
          if (hold_cnt_q != '1) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
          if (timeout) begin
            rr_ptr_d = next_ptr;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready generation: arbiter grant in IDLE, locked channel only in HALF.
  // Held low during reset so nothing is accepted while rstn is asserted.
  always_comb begin
    din_rdy = '0;
    if (rstn) begin
      case (state_q)
        IDLE:    din_rdy = any_req ? gnt : '0;
        HALF:    din_rdy[lock_ch_q] = 1'b1;
        default: din_rdy = '0;
      endcase
    end
  end

  assign dout_vld = dout_vld_q;
  assign dout     = dout_q;
  assign dout_ch  = dout_ch_q;
  assign err_drop = err_q;

endmodule

// File: tb/tb_simple_adapter_arb.sv
// tb_simple_adapter_arb
//   Directed bench for simple_adapter_arb. Three instances share clock
//   and reset: a default NCH=4 arbiter, an NCH=4 arbiter with a short
//   hold timeout, and an NCH=3 arbiter with the timeout disabled for the
//   random soak.
module tb_simple_adapter_arb;

  logic clk = 1'b0;
  logic rstn = 1'b1;

  always #5 clk = ~clk;

  logic [3:0]  vldA;  logic [31:0] dinA;  logic [3:0] rdyA;
  logic        doutVldA; logic [15:0] doutA; logic [1:0] chA; logic errA;

  logic [3:0]  vldT;  logic [31:0] dinT;  logic [3:0] rdyT;
  logic        doutVldT; logic [15:0] doutT; logic [1:0] chT; logic errT;

  logic [2:0]  vldS;  logic [23:0] dinS;  logic [2:0] rdyS;
  logic        doutVldS; logic [15:0] doutS; logic [1:0] chS; logic errS;

  int nChecks = 0;
  int nFail   = 0;

  simple_adapter_arb #(.NCH(4), .WIDTH_DIN(8), .HOLD_MAX(64)) dutA (
    .clk(clk), .rstn(rstn), .din_vld(vldA), .din(dinA), .din_rdy(rdyA),
    .dout_vld(doutVldA), .dout(doutA), .dout_ch(chA), .err_drop(errA));

  simple_adapter_arb #(.NCH(4), .WIDTH_DIN(8), .HOLD_MAX(4)) dutT (
    .clk(clk), .rstn(rstn), .din_vld(vldT), .din(dinT), .din_rdy(rdyT),
    .dout_vld(doutVldT), .dout(doutT), .dout_ch(chT), .err_drop(errT));

  simple_adapter_arb #(.NCH(3), .WIDTH_DIN(8), .HOLD_MAX(0)) dutS (
    .clk(clk), .rstn(rstn), .din_vld(vldS), .din(dinS), .din_rdy(rdyS),
    .dout_vld(doutVldS), .dout(doutS), .dout_ch(chS), .err_drop(errS));

  // Advance to just after the next rising edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Two-cycle reset with all inputs quiet; released away from the edge.
  task automatic pulseReset;
    vldA = '0; vldT = '0; vldS = '0;
    rstn = 1'b0;
    step;
    step;
    rstn = 1'b1;
  endtask

  task automatic test_reset;
    vldA = '1; vldT = '1; vldS = '1;
    dinA = '0; dinT = '0; dinS = '0;
    #1 rstn = 1'b0;
    #2;
    step;
    nChecks++; if (rdyA !== 4'b0000) begin nFail++; $display("[TB] FAIL reset_rdyA got=%b exp=0000", rdyA); end
    nChecks++; if (rdyT !== 4'b0000) begin nFail++; $display("[TB] FAIL reset_rdyT got=%b exp=0000", rdyT); end
    nChecks++; if (rdyS !== 3'b000) begin nFail++; $display("[TB] FAIL reset_rdyS got=%b exp=000", rdyS); end
    nChecks++; if (doutVldA !== 1'b0) begin nFail++; $display("[TB] FAIL reset_doutVld got=%b exp=0", doutVldA); end
    nChecks++; if (doutA !== 16'h0000) begin nFail++; $display("[TB] FAIL reset_dout got=%h exp=0000", doutA); end
    nChecks++; if (chA !== 2'd0) begin nFail++; $display("[TB] FAIL reset_doutCh got=%0d exp=0", chA); end
    nChecks++; if (errA !== 1'b0) begin nFail++; $display("[TB] FAIL reset_errDrop got=%b exp=0", errA); end
    vldA = '0; vldT = '0; vldS = '0;
    step;
    rstn = 1'b1;
  endtask

  task automatic test_single;
    vldA = 4'b0100;
    dinA = '0;
    dinA[23:16] = 8'hA5;
    #1;
    nChecks++; if (rdyA !== 4'b0100) begin nFail++; $display("[TB] FAIL single_rdy1 got=%b exp=0100", rdyA); end
    step;
    dinA[23:16] = 8'h3C;
    #1;
    nChecks++; if (rdyA !== 4'b0100) begin nFail++; $display("[TB] FAIL single_rdy2 got=%b exp=0100", rdyA); end
    nChecks++; if (doutVldA !== 1'b0) begin nFail++; $display("[TB] FAIL single_early_vld got=%b exp=0", doutVldA); end
    step;
    nChecks++; if (doutVldA !== 1'b1) begin nFail++; $display("[TB] FAIL single_vld got=%b exp=1", doutVldA); end
    nChecks++; if (doutA !== 16'hA53C) begin nFail++; $display("[TB] FAIL single_dout got=%h exp=a53c", doutA); end
    nChecks++; if (chA !== 2'd2) begin nFail++; $display("[TB] FAIL single_ch got=%0d exp=2", chA); end
    vldA = '0;
    step;
    nChecks++; if (doutVldA !== 1'b0) begin nFail++; $display("[TB] FAIL single_pulse got=%b exp=0", doutVldA); end
    nChecks++; if (doutA !== 16'hA53C) begin nFail++; $display("[TB] FAIL single_hold got=%h exp=a53c", doutA); end
  endtask

  task automatic test_all_channels;
    int bc [4];
    logic [3:0] rdySnap;
    int pulses;
    int expCh;
    logic [7:0] expHi;
    pulseReset;
    pulses = 0;
    for (int k = 0; k < 4; k++) bc[k] = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      vldA = 4'b1111;
      for (int k = 0; k < 4; k++) dinA[k*8 +: 8] = 8'((k << 4) | bc[k]);
      #1;
      rdySnap = rdyA;
      nChecks++; if (!$onehot(rdyA)) begin nFail++; $display("[TB] FAIL all_onehot cyc=%0d got=%b exp=onehot", cyc, rdyA); end
      step;
      for (int k = 0; k < 4; k++) if (rdySnap[k]) bc[k]++;
      if (doutVldA) begin
        expCh = pulses % 4;
        expHi = 8'((expCh << 4) | (2 * (pulses / 4)));
        nChecks++; if (chA !== 2'(expCh)) begin nFail++; $display("[TB] FAIL all_ch pair=%0d got=%0d exp=%0d", pulses, chA, expCh); end
        nChecks++; if (doutA !== {expHi, expHi + 8'd1}) begin nFail++; $display("[TB] FAIL all_dout pair=%0d got=%h exp=%h", pulses, doutA, {expHi, expHi + 8'd1}); end
        pulses++;
      end
    end
    vldA = '0;
    nChecks++; if (pulses != 5) begin nFail++; $display("[TB] FAIL all_count got=%0d exp=5", pulses); end
  endtask

  task automatic test_lock;
    vldA = 4'b1011;
    dinA = 32'h0F00_110E;
    #1;
    nChecks++; if (rdyA !== 4'b0010) begin nFail++; $display("[TB] FAIL lock_first_rdy got=%b exp=0010", rdyA); end
    step;
    vldA = 4'b1001;
    for (int i = 0; i < 5; i++) begin
      #1;
      nChecks++; if (rdyA !== 4'b0010) begin nFail++; $display("[TB] FAIL lock_hold_rdy i=%0d got=%b exp=0010", i, rdyA); end
      nChecks++; if (doutVldA !== 1'b0) begin nFail++; $display("[TB] FAIL lock_hold_vld i=%0d got=%b exp=0", i, doutVldA); end
      step;
    end
    vldA = 4'b1011;
    dinA[15:8] = 8'h22;
    #1;
    nChecks++; if (rdyA !== 4'b0010) begin nFail++; $display("[TB] FAIL lock_second_rdy got=%b exp=0010", rdyA); end
    step;
    nChecks++; if (doutVldA !== 1'b1) begin nFail++; $display("[TB] FAIL lock_vld got=%b exp=1", doutVldA); end
    nChecks++; if (doutA !== 16'h1122) begin nFail++; $display("[TB] FAIL lock_dout got=%h exp=1122", doutA); end
    nChecks++; if (chA !== 2'd1) begin nFail++; $display("[TB] FAIL lock_ch got=%0d exp=1", chA); end
    vldA = 4'b1001;
    #1;
    nChecks++; if (rdyA !== 4'b1000) begin nFail++; $display("[TB] FAIL lock_next_grant got=%b exp=1000", rdyA); end
    vldA = '0;
    step;
  endtask

  task automatic test_timeout;
    pulseReset;
    vldT = 4'b0001;
    dinT = '0;
    dinT[7:0] = 8'hAA;
    #1;
    nChecks++; if (rdyT !== 4'b0001) begin nFail++; $display("[TB] FAIL tmo_first_rdy got=%b exp=0001", rdyT); end
    step;
    vldT = '0;
    for (int i = 1; i <= 5; i++) begin
      #1;
      nChecks++; if (rdyT !== ((i <= 4) ? 4'b0001 : 4'b0000)) begin nFail++; $display("[TB] FAIL tmo_rdy i=%0d got=%b exp=%b", i, rdyT, (i <= 4) ? 4'b0001 : 4'b0000); end
      step;
      nChecks++; if (errT !== (i == 4)) begin nFail++; $display("[TB] FAIL tmo_err i=%0d got=%b exp=%b", i, errT, (i == 4)); end
      nChecks++; if (doutVldT !== 1'b0) begin nFail++; $display("[TB] FAIL tmo_vld i=%0d got=%b exp=0", i, doutVldT); end
    end
    vldT = 4'b0001;
    dinT[7:0] = 8'h5A;
    #1;
    nChecks++; if (rdyT !== 4'b0001) begin nFail++; $display("[TB] FAIL tmo2_first_rdy got=%b exp=0001", rdyT); end
    step;
    vldT = '0;
    for (int i = 1; i <= 3; i++) begin
      step;
      nChecks++; if (errT !== 1'b0) begin nFail++; $display("[TB] FAIL tmo2_err i=%0d got=%b exp=0", i, errT); end
      nChecks++; if (doutVldT !== 1'b0) begin nFail++; $display("[TB] FAIL tmo2_vld i=%0d got=%b exp=0", i, doutVldT); end
    end
    vldT = 4'b0001;
    dinT[7:0] = 8'h6B;
    #1;
    nChecks++; if (rdyT !== 4'b0001) begin nFail++; $display("[TB] FAIL tmo2_second_rdy got=%b exp=0001", rdyT); end
    step;
    vldT = '0;
    nChecks++; if (doutVldT !== 1'b1) begin nFail++; $display("[TB] FAIL tmo2_out_vld got=%b exp=1", doutVldT); end
    nChecks++; if (doutT !== 16'h5A6B) begin nFail++; $display("[TB] FAIL tmo2_dout got=%h exp=5a6b", doutT); end
    nChecks++; if (chT !== 2'd0) begin nFail++; $display("[TB] FAIL tmo2_ch got=%0d exp=0", chT); end
    nChecks++; if (errT !== 1'b0) begin nFail++; $display("[TB] FAIL tmo2_out_err got=%b exp=0", errT); end
    step;
    nChecks++; if (errT !== 1'b0) begin nFail++; $display("[TB] FAIL tmo2_late_err got=%b exp=0", errT); end
  endtask

  task automatic test_reset_mid_half;
    vldA = 4'b0100;
    dinA = '0;
    dinA[23:16] = 8'hFF;
    #1;
    nChecks++; if (rdyA !== 4'b0100) begin nFail++; $display("[TB] FAIL rmid_first_rdy got=%b exp=0100", rdyA); end
    step;
    rstn = 1'b0;
    #1;
    nChecks++; if (rdyA !== 4'b0000) begin nFail++; $display("[TB] FAIL rmid_rdy got=%b exp=0000", rdyA); end
    nChecks++; if (doutA !== 16'h0000) begin nFail++; $display("[TB] FAIL rmid_dout got=%h exp=0000", doutA); end
    nChecks++; if (chA !== 2'd0) begin nFail++; $display("[TB] FAIL rmid_ch got=%0d exp=0", chA); end
    nChecks++; if (doutVldA !== 1'b0 || errA !== 1'b0) begin nFail++; $display("[TB] FAIL rmid_pulses got=%b%b exp=00", doutVldA, errA); end
    step;
    step;
    rstn = 1'b1;
    dinA[23:16] = 8'h01;
    #1;
    nChecks++; if (rdyA !== 4'b0100) begin nFail++; $display("[TB] FAIL rmid_rdy_a got=%b exp=0100", rdyA); end
    step;
    dinA[23:16] = 8'h02;
    #1;
    nChecks++; if (rdyA !== 4'b0100) begin nFail++; $display("[TB] FAIL rmid_rdy_b got=%b exp=0100", rdyA); end
    step;
    vldA = '0;
    nChecks++; if (doutVldA !== 1'b1) begin nFail++; $display("[TB] FAIL rmid_vld got=%b exp=1", doutVldA); end
    nChecks++; if (doutA !== 16'h0102) begin nFail++; $display("[TB] FAIL rmid_out got=%h exp=0102", doutA); end
    nChecks++; if (chA !== 2'd2) begin nFail++; $display("[TB] FAIL rmid_out_ch got=%0d exp=2", chA); end
    step;
  endtask

  task automatic test_soak;
    logic [7:0] sdata [3][1024];
    int idx [3];
    int outCnt [3];
    int errCnt;
    int cyc;
    int p;
    logic [2:0] rdySnap;
    logic [2:0] vldSnap;
    for (int run = 0; run < 4; run++) begin
      for (int k = 0; k < 3; k++) begin
        idx[k] = 0;
        outCnt[k] = 0;
        for (int j = 0; j < 1024; j++) sdata[k][j] = 8'($urandom_range(0, 255));
      end
      errCnt = 0;
      cyc = 0;
      while ((outCnt[0] < 512 || outCnt[1] < 512 || outCnt[2] < 512) && cyc < 20000) begin
        for (int k = 0; k < 3; k++) begin
          vldS[k] = (idx[k] < 1024) && ($urandom_range(0, 99) >= 20);
          dinS[k*8 +: 8] = (idx[k] < 1024) ? sdata[k][idx[k]] : 8'h00;
        end
        #1;
        rdySnap = rdyS;
        vldSnap = vldS;
        nChecks++; if (!$onehot0(rdyS)) begin nFail++; $display("[TB] FAIL soak_onehot run=%0d got=%b exp=onehot0", run, rdyS); end
        step;
        for (int k = 0; k < 3; k++) if (rdySnap[k] && vldSnap[k]) idx[k]++;
        if (errS) errCnt++;
        if (doutVldS) begin
          nChecks++;
          if (chS > 2'd2) begin
            nFail++; $display("[TB] FAIL soak_ch run=%0d got=%0d exp=0..2", run, chS);
          end else begin
            p = outCnt[chS];
            if (p >= 512) begin
              nFail++; $display("[TB] FAIL soak_extra run=%0d ch=%0d got=%0d exp=<512", run, chS, p);
            end else if (doutS !== {sdata[chS][2*p], sdata[chS][2*p+1]}) begin
              nFail++; $display("[TB] FAIL soak_dout run=%0d ch=%0d pair=%0d got=%h exp=%h", run, chS, p, doutS, {sdata[chS][2*p], sdata[chS][2*p+1]});
            end
            outCnt[chS]++;
          end
        end
        cyc++;
      end
      vldS = '0;
      nChecks++; if (cyc >= 20000) begin nFail++; $display("[TB] FAIL soak_budget run=%0d got=%0d/%0d/%0d exp=512 each", run, outCnt[0], outCnt[1], outCnt[2]); end
      nChecks++; if (errCnt != 0) begin nFail++; $display("[TB] FAIL soak_err run=%0d got=%0d exp=0", run, errCnt); end
      step;
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset;
    test_single;
    test_all_channels;
    test_lock;
    test_timeout;
    test_reset_mid_half;
    test_soak;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
